// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out capture path.
// Holds FSM state encodings and a constant clog2.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_bit_timer.sv
// Bit-rate divider for the capture path.
// tick marks a full bit period, half marks mid-start-bit.
module sipo_bit_timer
  import sipo_pkg::*;
#(
  parameter int DIV   = 16,
  parameter int CNT_W = clog2(DIV)
) (
  input  logic clk1,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick,
  output logic half
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(DIV - 1));
  assign half = (cnt_q == CNT_W'(DIV / 2 - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial frame capture controller: start detect, mid-bit sampling,
// MSB-first shift, stop check and valid/ready delivery.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 16,
  parameter int CNT_W = clog2(DIV)
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             si,
  input  logic             en,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);

  localparam int BC_W = clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             prev_si_q, prev_si_d;

  logic tmr_clr;
  logic tmr_run;
  logic tick;
  logic half;
  logic deliver;
  logic ovr_set;

  sipo_bit_timer #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk1 (clk1),
    .rst  (rst),
    .clr  (tmr_clr),
    .run  (tmr_run),
    .tick (tick),
    .half (half)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    frame_err_d = 1'b0;
    prev_si_d   = si;
    tmr_clr     = 1'b0;
    tmr_run     = (state_q != ST_IDLE);
    deliver     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (en && prev_si_q && !si) state_d = ST_START;
      end
      ST_START: begin
        if (half) begin
          tmr_clr = 1'b1;
          if (si) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_SHIFT;
            bitcnt_d = '0;
          end
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          shreg_d  = {shreg_q[WIDTH-2:0], si};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BC_W'(WIDTH - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          if (si) deliver     = 1'b1;
          else    frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new word may replace the held one only if it leaves this cycle.
  always_comb begin
    po_d       = po_q;
    po_valid_d = po_valid_q;
    ovr_set    = 1'b0;
    if (deliver) begin
      if (!po_valid_q || po_ready) begin
        po_d       = shreg_q;
        po_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (po_valid_q && po_ready) begin
      po_valid_d = 1'b0;
    end
    overrun_d = overrun_q;
    if (ovr_set)      overrun_d = 1'b1;
    else if (clr_err) overrun_d = 1'b0;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      po_q        <= '0;
      po_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      prev_si_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      po_q        <= po_d;
      po_valid_q  <= po_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      prev_si_q   <= prev_si_d;
    end
  end

  assign po        = po_q;
  assign po_valid  = po_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
